evaluate_pst: RTL and testbench

//  Multi-cycle static board evaluator: material plus positional terms (pawn advance,

---
 rtl/evaluate_pst.sv | 151 +++++++++++++++
 tb/tb_evaluate_pst.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/evaluate_pst.sv
// rtl/evaluate_pst.sv - multi-cycle material plus piece-square board evaluator.
`ifndef PIECE_BITS
`define PIECE_BITS 4
`endif

module evaluate_pst #(
  parameter int PIECE_WIDTH       = `PIECE_BITS,
  parameter int BOARD_WIDTH       = PIECE_WIDTH * 64,
  parameter int EVAL_WIDTH        = 22,
  parameter int SQUARES_PER_CYCLE = 8,
  parameter int PAWN_ADVANCE      = 10,
  parameter int CENTRE_BONUS      = 20,
  parameter bit SIDE_RELATIVE     = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         board_valid,
  input  logic [BOARD_WIDTH-1:0]       board_in,
  input  logic                         white_to_move_in,
  output logic                         ready,
  output logic signed [EVAL_WIDTH-1:0] eval,
  output logic                         eval_valid
);

  // Wide enough that 64 kings of one colour cannot overflow, whatever EVAL_WIDTH is.
  localparam int ACC_WIDTH = (EVAL_WIDTH + 4 > 24) ? EVAL_WIDTH + 4 : 24;
  localparam int KW        = PIECE_WIDTH - 1;
  localparam int SHIFT     = SQUARES_PER_CYCLE * PIECE_WIDTH;

  localparam logic [KW-1:0] T_PAWN = KW'(1);
  localparam logic [KW-1:0] T_KNIT = KW'(2);
  localparam logic [KW-1:0] T_BISH = KW'(3);
  localparam logic [KW-1:0] T_ROOK = KW'(4);
  localparam logic [KW-1:0] T_QUEN = KW'(5);
  localparam logic [KW-1:0] T_KING = KW'(6);

  localparam logic [5:0] STEP     = 6'(SQUARES_PER_CYCLE);
  localparam logic [5:0] LAST_IDX = 6'(64 - SQUARES_PER_CYCLE);

  localparam logic signed [ACC_WIDTH-1:0] EVAL_MAX =
    {{(ACC_WIDTH-EVAL_WIDTH+1){1'b0}}, {(EVAL_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] EVAL_MIN =
    {{(ACC_WIDTH-EVAL_WIDTH+1){1'b1}}, {(EVAL_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                        state, state_next;
  logic [BOARD_WIDTH-1:0]        board_q;
  logic                          white_to_move_q;
  logic [5:0]                    idx;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [ACC_WIDTH-1:0]   slice_sum;
  logic signed [ACC_WIDTH-1:0]   oriented;
  logic signed [ACC_WIDTH-1:0]   saturated;

  function automatic logic signed [ACC_WIDTH-1:0] term(
    input logic [PIECE_WIDTH-1:0] piece,
    input logic [5:0]             sq
  );
    logic [KW-1:0] kind;
    logic          black;
    int            row, col, adv, v;
    kind  = piece[KW-1:0];
    black = piece[PIECE_WIDTH-1];
    row   = int'(sq[5:3]);
    col   = int'(sq[2:0]);
    adv   = black ? 6 - row : row - 1;
    if (adv < 0) adv = 0;
    case (kind)
      T_PAWN:  v = 100 + adv * PAWN_ADVANCE;
      T_KNIT:  v = 310;
      T_BISH:  v = 320;
      T_ROOK:  v = 500;
      T_QUEN:  v = 900;
      T_KING:  v = 10000;
      default: v = 0;
    endcase
    if ((kind == T_KNIT || kind == T_BISH) && (row == 3 || row == 4) && (col == 3 || col == 4))
      v = v + CENTRE_BONUS;
    if (black) v = -v;
    return ACC_WIDTH'(v);
  endfunction

  // The latched board is shifted down each scan cycle, so the current slice is always the low squares.
  always_comb begin
    slice_sum = '0;
    for (int k = 0; k < SQUARES_PER_CYCLE; k++)
      slice_sum = slice_sum + term(board_q[k*PIECE_WIDTH +: PIECE_WIDTH], idx + 6'(k));
  end

  always_comb begin
    oriented = (SIDE_RELATIVE && !white_to_move_q) ? -acc : acc;
    if (oriented > EVAL_MAX)
      saturated = EVAL_MAX;
    else if (oriented < EVAL_MIN)
      saturated = EVAL_MIN;
    else
      saturated = oriented;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (board_valid) state_next = SCAN;
      SCAN:    if (idx == LAST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      board_q         <= '0;
      white_to_move_q <= 1'b0;
      idx             <= '0;
      acc             <= '0;
      eval            <= '0;
      eval_valid      <= 1'b0;
    end else begin
      eval_valid <= 1'b0;
      case (state)
        IDLE: if (board_valid) begin
          board_q         <= board_in;
          white_to_move_q <= white_to_move_in;
          idx             <= '0;
          acc             <= '0;
        end
        SCAN: begin
          acc     <= acc + slice_sum;
          idx     <= idx + STEP;
          board_q <= board_q >> SHIFT;
        end
        DONE: begin
          eval       <= saturated[EVAL_WIDTH-1:0];
          eval_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_evaluate_pst.sv
// tb/tb_evaluate_pst.sv - randomized self-checking bench for evaluate_pst across several parameter sets.
module tb_evaluate_pst;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         bv = 1'b0;
  logic [255:0] board = '0;
  logic         wtm = 1'b1;
  logic [4:0]   vld, rdy;
  logic [21:0]  e0, e1, e2, e3;
  logic [9:0]   e4;
  int           ev [5];
  int           cyc = 0;
  int           pulses [5] = '{default: 0};
  int           last_cyc [5] = '{default: 0};
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: S=8, 1: S=1, 2: S=64, 3: S=8 side-relative, 4: S=8 EVAL_WIDTH=10
  evaluate_pst u0 (.clk(clk), .reset_n(reset_n), .board_valid(bv), .board_in(board),
    .white_to_move_in(wtm), .ready(rdy[0]), .eval(e0), .eval_valid(vld[0]));
  evaluate_pst #(.SQUARES_PER_CYCLE(1)) u1 (.clk(clk), .reset_n(reset_n), .board_valid(bv),
    .board_in(board), .white_to_move_in(wtm), .ready(rdy[1]), .eval(e1), .eval_valid(vld[1]));
  evaluate_pst #(.SQUARES_PER_CYCLE(64)) u2 (.clk(clk), .reset_n(reset_n), .board_valid(bv),
    .board_in(board), .white_to_move_in(wtm), .ready(rdy[2]), .eval(e2), .eval_valid(vld[2]));
  evaluate_pst #(.SIDE_RELATIVE(1'b1)) u3 (.clk(clk), .reset_n(reset_n), .board_valid(bv),
    .board_in(board), .white_to_move_in(wtm), .ready(rdy[3]), .eval(e3), .eval_valid(vld[3]));
  evaluate_pst #(.EVAL_WIDTH(10)) u4 (.clk(clk), .reset_n(reset_n), .board_valid(bv),
    .board_in(board), .white_to_move_in(wtm), .ready(rdy[4]), .eval(e4), .eval_valid(vld[4]));

  always_comb begin
    ev[0] = int'($signed(e0));
    ev[1] = int'($signed(e1));
    ev[2] = int'($signed(e2));
    ev[3] = int'($signed(e3));
    ev[4] = int'($signed(e4));
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 5; i++)
      if (vld[i] === 1'b1) begin
        pulses[i]   = pulses[i] + 1;
        last_cyc[i] = cyc;
      end
  end

  function automatic int n_of(int i);
    case (i)
      1: return 64;
      2: return 1;
      default: return 8;
    endcase
  endfunction

  function automatic int model(logic [255:0] b, bit w, int rel, int ew);
    int total = 0;
    int values [8] = '{0, 100, 310, 320, 500, 900, 10000, 0};
    for (int sq = 0; sq < 64; sq++) begin
      logic [3:0] code;
      int row, col, v, adv;
      code = b[sq*4 +: 4];
      row  = sq / 8;
      col  = sq % 8;
      v    = values[code[2:0]];
      if (code[2:0] == 3'd1) begin
        adv = code[3] ? (6 - row) : (row - 1);
        v = v + ((adv > 0) ? adv : 0) * 10;
      end
      if ((code[2:0] == 3'd2 || code[2:0] == 3'd3) && row >= 3 && row <= 4 && col >= 3 && col <= 4)
        v = v + 20;
      total = code[3] ? total - v : total + v;
    end
    if (rel != 0 && !w) total = -total;
    if (total > (1 << (ew - 1)) - 1) total = (1 << (ew - 1)) - 1;
    if (total < -(1 << (ew - 1))) total = -(1 << (ew - 1));
    return total;
  endfunction

  function automatic logic [255:0] put(logic [255:0] b, int sq, logic [3:0] code);
    logic [255:0] r;
    r = b;
    r[sq*4 +: 4] = code;
    return r;
  endfunction

  function automatic logic [255:0] random_board();
    logic [255:0] r = '0;
    for (int sq = 0; sq < 64; sq++)
      if ($urandom_range(0, 99) >= 55) r[sq*4 +: 4] = 4'($urandom_range(0, 15));
    return r;
  endfunction

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (rdy !== 5'h1f && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 200) begin
      errors++;
      $display("FAIL wait_idle: ready=%b required 11111 within 200 cycles", rdy);
    end
  endtask

  task automatic run_board(input logic [255:0] b, input bit w, input string name);
    int p0 [5];
    int acc_c, exp_v;
    wait_idle();
    for (int i = 0; i < 5; i++) p0[i] = pulses[i];
    board = b;
    wtm = w;
    bv = 1'b1;
    @(posedge clk);
    #1 acc_c = cyc;
    @(negedge clk);
    bv = 1'b0;
    repeat (70) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      exp_v = model(b, w, (i == 3) ? 1 : 0, (i == 4) ? 10 : 22);
      checks++;
      if (pulses[i] - p0[i] !== 1) begin
        errors++;
        $display("FAIL %s pulses[%0d]: got %0d required 1", name, i, pulses[i] - p0[i]);
      end
      checks++;
      if (last_cyc[i] - acc_c !== n_of(i) + 1) begin
        errors++;
        $display("FAIL %s latency[%0d]: got %0d required %0d", name, i, last_cyc[i] - acc_c, n_of(i) + 1);
      end
      checks++;
      if (ev[i] !== exp_v) begin
        errors++;
        $display("FAIL %s eval[%0d]: got %0d required %0d", name, i, ev[i], exp_v);
      end
    end
  endtask

  task automatic check_eval(input int i, input int required, input string name);
    checks++;
    if (ev[i] !== required) begin
      errors++;
      $display("FAIL %s eval[%0d]: got %0d required %0d", name, i, ev[i], required);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rdy[i] !== 1'b1 || vld[i] !== 1'b0 || ev[i] !== 0) begin
        errors++;
        $display("FAIL reset[%0d]: ready=%b eval_valid=%b eval=%0d required 1 0 0", i, rdy[i], vld[i], ev[i]);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_start_position();
    logic [255:0] b = '0;
    logic [3:0] back [8] = '{4'd4, 4'd2, 4'd3, 4'd5, 4'd6, 4'd3, 4'd2, 4'd4};
    for (int c = 0; c < 8; c++) begin
      b = put(b, c, back[c]);
      b = put(b, 8 + c, 4'd1);
      b = put(b, 48 + c, 4'd9);
      b = put(b, 56 + c, back[c] | 4'd8);
    end
    run_board(b, 1'b1, "start");
    check_eval(0, 0, "start_const");
  endtask

  task automatic test_centre_and_pawn();
    logic [255:0] kings, b;
    kings = put(put('0, 4, 4'd6), 60, 4'd14);
    b = put(kings, 28, 4'd2);
    run_board(b, 1'b1, "knight_e4");
    check_eval(0, 330, "knight_e4_const");
    b = put(kings, 52, 4'd1);
    run_board(b, 1'b0, "pawn_e7_black_moves");
    check_eval(0, 150, "pawn_e7_abs");
    check_eval(3, -150, "pawn_e7_rel_black");
    run_board(b, 1'b1, "pawn_e7_white_moves");
    check_eval(3, 150, "pawn_e7_rel_white");
  endtask

  task automatic test_saturation();
    logic [255:0] kings;
    kings = put(put('0, 4, 4'd6), 60, 4'd14);
    run_board(put(kings, 0, 4'd5), 1'b1, "queen_a1");
    check_eval(4, 511, "sat_high");
    check_eval(0, 900, "queen_a1_wide");
    run_board(put(kings, 56, 4'd13), 1'b1, "queen_a8");
    check_eval(4, -512, "sat_low");
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++)
      run_board(random_board(), 1'($urandom_range(0, 1)), "random");
  endtask

  task automatic test_back_to_back();
    logic [255:0] b;
    int p0 [5];
    int req, exp_v;
    b = random_board();
    wait_idle();
    for (int i = 0; i < 5; i++) p0[i] = pulses[i];
    board = b;
    wtm = 1'b0;
    bv = 1'b1;
    repeat (200) @(negedge clk);
    bv = 1'b0;
    repeat (80) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      req = (200 + n_of(i) + 1) / (n_of(i) + 2);
      exp_v = model(b, 1'b0, (i == 3) ? 1 : 0, (i == 4) ? 10 : 22);
      checks++;
      if (pulses[i] - p0[i] !== req) begin
        errors++;
        $display("FAIL back_to_back pulses[%0d]: got %0d required %0d", i, pulses[i] - p0[i], req);
      end
      check_eval(i, exp_v, "back_to_back");
    end
  endtask

  task automatic test_reset_mid_scan();
    int p0 [5];
    wait_idle();
    board = random_board();
    wtm = 1'b1;
    bv = 1'b1;
    @(negedge clk);
    bv = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) p0[i] = pulses[i];
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rdy[i] !== 1'b1 || ev[i] !== 0) begin
        errors++;
        $display("FAIL mid_reset_async[%0d]: ready=%b eval=%0d required 1 0", i, rdy[i], ev[i]);
      end
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (80) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (pulses[i] !== p0[i] || ev[i] !== 0 || rdy[i] !== 1'b1) begin
        errors++;
        $display("FAIL mid_reset_after[%0d]: extra_pulses=%0d eval=%0d ready=%b required 0 0 1",
                 i, pulses[i] - p0[i], ev[i], rdy[i]);
      end
    end
    run_board(random_board(), 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_start_position();
    test_centre_and_pawn();
    test_saturation();
    test_random();
    test_back_to_back();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
